// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared opcode, ALU-op, rstatus constants and FSM state type
// for the write-back controller.
package wb_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // rstatus codes written to r30 on overflow; 0 means "no redirect"
  localparam logic [2:0] RS_NONE = 3'd0;
  localparam logic [2:0] RS_ADD  = 3'd1;
  localparam logic [2:0] RS_ADDI = 3'd2;
  localparam logic [2:0] RS_SUB  = 3'd3;
  localparam logic [2:0] RS_MUL  = 3'd4;
  localparam logic [2:0] RS_DIV  = 3'd5;

  localparam int REG_RSTATUS = 30;
  localparam int REG_RA      = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } md_state_e;

endpackage

// File: rtl/wb_decode.sv
// rtl/wb_decode.sv - combinational W-stage decode: write class, destination,
// mult/div detection and overflow rstatus code.
module wb_decode
  import wb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 5
) (
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic              writes_o,
  output logic [ADDR_W-1:0] dest_o,
  output logic              is_md_o,
  output logic [2:0]        ovf_code_o
);

  always_comb begin
    writes_o   = 1'b0;
    dest_o     = rd_i;
    is_md_o    = 1'b0;
    ovf_code_o = RS_NONE;
    case (opcode_i)
      OP_RTYPE: begin
        // every R-type writes except mul/div, which complete later via the md path
        writes_o = 1'b1;
        is_md_o  = (aluop_i == ALU_MUL) || (aluop_i == ALU_DIV);
        if (aluop_i == ALU_ADD) ovf_code_o = RS_ADD;
        if (aluop_i == ALU_SUB) ovf_code_o = RS_SUB;
      end
      OP_ADDI: begin
        writes_o   = 1'b1;
        ovf_code_o = RS_ADDI;
      end
      OP_LW: writes_o = 1'b1;
      OP_JAL: begin
        writes_o = 1'b1;
        dest_o   = ADDR_W'(REG_RA);
      end
      OP_SETX: begin
        writes_o = 1'b1;
        dest_o   = ADDR_W'(REG_RSTATUS);
      end
      default: writes_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_ctrl.sv
// rtl/wb_ctrl.sv - write-back controller: arbitrates W-stage writes against
// out-of-band mult/div results and tracks the pending mult/div destination.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [OP_W-1:0]     in_opcode,
  input  logic [OP_W-1:0]     in_aluop,
  input  logic [ADDR_W-1:0]   in_rd,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_ovf,
  output logic                in_ready,
  input  logic                md_issue,
  input  logic [ADDR_W-1:0]   md_issue_rd,
  input  logic                md_issue_isdiv,
  input  logic                md_resp_valid,
  input  logic [DATA_W-1:0]   md_resp_data,
  input  logic                md_resp_ovf,
  output logic                ctrl_writeEnable,
  output logic [ADDR_W-1:0]   ctrl_writeReg,
  output logic [DATA_W-1:0]   ctrl_writeData,
  output logic                md_pending,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                proto_err
);

  md_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   md_rd_q, md_rd_d;
  logic                md_div_q, md_div_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                perr_q, perr_d;

  logic                dec_writes, dec_is_md;
  logic [ADDR_W-1:0]   dec_dest;
  logic [2:0]          dec_ovf_code;

  wb_decode #(.ADDR_W(ADDR_W), .OP_W(OP_W)) u_decode (
    .opcode_i   (in_opcode),
    .aluop_i    (in_aluop),
    .rd_i       (in_rd),
    .writes_o   (dec_writes),
    .dest_o     (dec_dest),
    .is_md_o    (dec_is_md),
    .ovf_code_o (dec_ovf_code)
  );

  logic              writing, accept, w_redirect;
  logic [ADDR_W-1:0] w_reg, md_reg;
  logic [DATA_W-1:0] w_data, md_data;

  assign writing    = dec_writes & ~dec_is_md;
  assign md_pending = (state_q == ST_PEND);
  assign in_ready   = ~md_resp_valid &
                      ~(in_valid & writing & (dec_dest == md_rd_q) & md_pending);
  assign accept     = in_valid & in_ready;

  assign w_redirect = in_ovf & (dec_ovf_code != RS_NONE);
  assign w_reg      = w_redirect ? ADDR_W'(REG_RSTATUS) : dec_dest;
  assign w_data     = w_redirect ? DATA_W'(dec_ovf_code) : in_data;

  assign md_reg     = md_resp_ovf ? ADDR_W'(REG_RSTATUS) : md_rd_q;
  assign md_data    = md_resp_ovf ? DATA_W'(md_div_q ? RS_DIV : RS_MUL) : md_resp_data;

  always_comb begin
    state_d  = state_q;
    md_rd_d  = md_rd_q;
    md_div_d = md_div_q;
    perr_d   = perr_q;
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (md_resp_valid) perr_d = 1'b1;
        if (md_issue) begin
          state_d  = ST_PEND;
          md_rd_d  = md_issue_rd;
          md_div_d = md_issue_isdiv;
        end
      end
      ST_PEND: begin
        if (md_resp_valid) begin
          we_d    = (md_reg != '0);
          wreg_d  = md_reg;
          wdata_d = md_data;
          if (md_issue) begin
            md_rd_d  = md_issue_rd;
            md_div_d = md_issue_isdiv;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (md_issue) begin
          perr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // accept is never true alongside md_resp_valid, so this cannot collide
    if (accept && writing) begin
      we_d    = (w_reg != '0);
      wreg_d  = w_reg;
      wdata_d = w_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      md_rd_q  <= '0;
      md_div_q <= 1'b0;
      perr_q   <= 1'b0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      md_rd_q  <= md_rd_d;
      md_div_q <= md_div_d;
      perr_q   <= perr_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign ctrl_writeData   = wdata_q;
  assign proto_err        = perr_q;
  assign busy_mask        = (md_pending && md_rd_q != '0) ? (NUM_REGS'(1) << md_rd_q) : '0;

endmodule

// File: tb/tb_wb_ctrl.sv
// tb/tb_wb_ctrl.sv - directed and randomized self-checking bench for wb_ctrl
// against an instruction-level reference model.
module tb_wb_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_opcode = '0, in_aluop = '0, in_rd = '0;
  logic [31:0] in_data = '0;
  logic        in_ovf = 1'b0;
  logic        in_ready;
  logic        md_issue = 1'b0;
  logic [4:0]  md_issue_rd = '0;
  logic        md_issue_isdiv = 1'b0;
  logic        md_resp_valid = 1'b0;
  logic [31:0] md_resp_data = '0;
  logic        md_resp_ovf = 1'b0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] ctrl_writeData;
  logic        md_pending;
  logic [31:0] busy_mask;
  logic        proto_err;

  wb_ctrl dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_opcode(in_opcode), .in_aluop(in_aluop),
    .in_rd(in_rd), .in_data(in_data), .in_ovf(in_ovf), .in_ready(in_ready),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd), .md_issue_isdiv(md_issue_isdiv),
    .md_resp_valid(md_resp_valid), .md_resp_data(md_resp_data), .md_resp_ovf(md_resp_ovf),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_writeData(ctrl_writeData), .md_pending(md_pending),
    .busy_mask(busy_mask), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model: one outstanding mult/div plus the sticky error flag
  bit         m_pend = 0;
  logic [4:0] m_rd = '0;
  bit         m_div = 0;
  bit         m_perr = 0;
  bit         last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_writes(input logic [4:0] op, input logic [4:0] alu);
    case (op)
      5'd0:                  return (alu != 5'd6) && (alu != 5'd7);
      5'd5, 5'd8, 5'd3, 5'd21: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] m_dest(input logic [4:0] op, input logic [4:0] rd);
    if (op == 5'd3)  return 5'd31;
    if (op == 5'd21) return 5'd30;
    return rd;
  endfunction

  function automatic logic [31:0] m_code(input logic [4:0] op, input logic [4:0] alu);
    if (op == 5'd0 && alu == 5'd0) return 32'd1;
    if (op == 5'd5)                return 32'd2;
    if (op == 5'd0 && alu == 5'd1) return 32'd3;
    return 32'd0;
  endfunction

  task automatic step(input string tag);
    bit          w, rdy_e, we_e;
    logic [4:0]  d, reg_e;
    logic [31:0] data_e, code;
    #1;
    w     = m_writes(in_opcode, in_aluop);
    d     = m_dest(in_opcode, in_rd);
    rdy_e = !md_resp_valid && !(in_valid && w && d == m_rd && m_pend);
    chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, rdy_e});
    last_acc = in_valid && rdy_e;
    we_e = 0; reg_e = '0; data_e = '0;
    if (md_resp_valid && m_pend) begin
      reg_e  = md_resp_ovf ? 5'd30 : m_rd;
      data_e = md_resp_ovf ? (m_div ? 32'd5 : 32'd4) : md_resp_data;
      we_e   = (reg_e != 0);
    end else if (last_acc && w) begin
      code   = m_code(in_opcode, in_aluop);
      reg_e  = (in_ovf && code != 0) ? 5'd30 : d;
      data_e = (in_ovf && code != 0) ? code : in_data;
      we_e   = (reg_e != 0);
    end
    if (md_resp_valid) begin
      if (!m_pend) m_perr = 1;
      if (m_pend && !md_issue) m_pend = 0;
      else if (md_issue) begin m_pend = 1; m_rd = md_issue_rd; m_div = md_issue_isdiv; end
    end else if (md_issue) begin
      if (m_pend) m_perr = 1;
      else begin m_pend = 1; m_rd = md_issue_rd; m_div = md_issue_isdiv; end
    end
    @(posedge clock);
    #1;
    chk({tag, ".we"}, {31'd0, ctrl_writeEnable}, {31'd0, we_e});
    if (we_e) begin
      chk({tag, ".reg"}, {27'd0, ctrl_writeReg}, {27'd0, reg_e});
      chk({tag, ".data"}, ctrl_writeData, data_e);
    end
    chk({tag, ".pend"}, {31'd0, md_pending}, {31'd0, m_pend});
    chk({tag, ".busy"}, busy_mask, (m_pend && m_rd != 0) ? (32'd1 << m_rd) : 32'd0);
    chk({tag, ".perr"}, {31'd0, proto_err}, {31'd0, m_perr});
  endtask

  task automatic idle();
    in_valid = 0; in_ovf = 0; md_issue = 0; md_resp_valid = 0; md_resp_ovf = 0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    #2;
    chk({tag, ".we"}, {31'd0, ctrl_writeEnable}, 32'd0);
    chk({tag, ".reg"}, {27'd0, ctrl_writeReg}, 32'd0);
    chk({tag, ".data"}, ctrl_writeData, 32'd0);
    chk({tag, ".pend"}, {31'd0, md_pending}, 32'd0);
    chk({tag, ".busy"}, busy_mask, 32'd0);
    chk({tag, ".perr"}, {31'd0, proto_err}, 32'd0);
    chk({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
    m_pend = 0; m_rd = '0; m_div = 0; m_perr = 0;
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  initial begin
    logic [4:0] ops [9];
    ops = '{5'd0, 5'd0, 5'd5, 5'd8, 5'd3, 5'd21, 5'd1, 5'd2, 5'd4};
    idle();
    @(posedge clock);
    #1;
    do_reset("rst0");

    // addi r5 <- 7, visible for one cycle only
    in_valid = 1; in_opcode = 5'd5; in_rd = 5'd5; in_data = 32'd7;
    step("addi5");
    chk("addi5.reg_k", {27'd0, ctrl_writeReg}, 32'd5);
    idle();
    step("addi5.gone");

    // overflowing add, jal, write to r0
    in_valid = 1; in_opcode = 5'd0; in_aluop = 5'd0; in_rd = 5'd4; in_ovf = 1; in_data = 32'hdead;
    step("addovf");
    chk("addovf.data_k", ctrl_writeData, 32'd1);
    in_ovf = 0; in_opcode = 5'd3; in_rd = 5'd2; in_data = 32'h40;
    step("jal");
    chk("jal.reg_k", {27'd0, ctrl_writeReg}, 32'd31);
    in_opcode = 5'd0; in_rd = 5'd0; in_data = 32'h99;
    step("add_r0");
    idle();

    // scoreboard stall on pending mult destination
    md_issue = 1; md_issue_rd = 5'd9; md_issue_isdiv = 0;
    step("iss9");
    md_issue = 0;
    in_valid = 1; in_opcode = 5'd5; in_rd = 5'd9; in_data = 32'h55;
    step("stall9a");
    chk("stall9a.busy_k", busy_mask, 32'h200);
    step("stall9b");
    md_resp_valid = 1; md_resp_data = 32'h20;
    step("resp9");
    chk("resp9.data_k", ctrl_writeData, 32'h20);
    md_resp_valid = 0;
    step("addi9");
    chk("addi9.data_k", ctrl_writeData, 32'h55);
    idle();

    // md result and lw collide: md first, lw next cycle
    md_issue = 1; md_issue_rd = 5'd12;
    step("iss12");
    md_issue = 0;
    md_resp_valid = 1; md_resp_data = 32'h1234;
    in_valid = 1; in_opcode = 5'd8; in_rd = 5'd3; in_data = 32'habc;
    step("col.md");
    chk("col.md.reg_k", {27'd0, ctrl_writeReg}, 32'd12);
    md_resp_valid = 0;
    step("col.lw");
    chk("col.lw.reg_k", {27'd0, ctrl_writeReg}, 32'd3);
    idle();

    // div overflow, then back-to-back resp+issue
    md_issue = 1; md_issue_rd = 5'd7; md_issue_isdiv = 1;
    step("iss7");
    md_issue = 0; md_resp_valid = 1; md_resp_ovf = 1;
    step("divovf");
    chk("divovf.data_k", ctrl_writeData, 32'd5);
    idle();
    md_issue = 1; md_issue_rd = 5'd8; md_issue_isdiv = 0;
    step("iss8");
    md_resp_valid = 1; md_resp_data = 32'h88; md_issue_rd = 5'd10;
    step("b2b");
    chk("b2b.busy_k", busy_mask, 32'h400);
    idle(); md_resp_valid = 1; md_resp_data = 32'haa;
    step("resp10");
    idle();

    // reset mid-PEND, then orphan response
    md_issue = 1; md_issue_rd = 5'd11;
    step("iss11");
    idle();
    do_reset("rst_mid");
    md_resp_valid = 1; md_resp_data = 32'h77;
    step("orphan");
    chk("orphan.perr_k", {31'd0, proto_err}, 32'd1);
    idle();

    // randomized traffic
    do_reset("rst_rnd");
    last_acc = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_opcode = ops[$urandom_range(0, 8)];
        in_aluop  = 5'($urandom_range(0, 7));
        in_rd     = 5'($urandom_range(0, 7));
        in_ovf    = ($urandom_range(0, 4) == 0);
        in_data   = $urandom;
      end
      md_issue       = m_pend ? ($urandom_range(0, 30) == 0) : ($urandom_range(0, 5) == 0);
      md_issue_rd    = 5'($urandom_range(0, 7));
      md_issue_isdiv = $urandom_range(0, 1) != 0;
      md_resp_valid  = m_pend ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
      md_resp_ovf    = ($urandom_range(0, 4) == 0);
      md_resp_data   = $urandom;
      step("rnd");
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter DATA_W, 32, register write-data width.
REQ-002 Parameter ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter OP_W, 5, opcode and ALU-op field width.
REQ-004 Ports shall be exactly, clock and reset first:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  W-stage instruction present.
- in_opcode  in  OP_W  instruction opcode.
- in_aluop  in  OP_W  R-type ALU op field.
- in_rd  in  ADDR_W  destination index.
- in_data  in  DATA_W  write-back value (ALU, load, PC+1 or zero-extended T).
- in_ovf  in  1  arithmetic overflow for this instruction.
- in_ready  out  1  W instruction accepted this cycle.
- md_issue  in  1  mult/div started in X.
- md_issue_rd  in  ADDR_W  mult/div destination.
- md_issue_isdiv  in  1  1=div, 0=mult.
- md_resp_valid  in  1  mult/div result available, one-cycle pulse.
- md_resp_data  in  DATA_W  mult/div result.
- md_resp_ovf  in  1  mult/div exception.
- ctrl_writeEnable  out  1  regfile write enable.
- ctrl_writeReg  out  ADDR_W  regfile write index.
- ctrl_writeData  out  DATA_W  regfile write data.
- md_pending  out  1  mult/div outstanding.
- busy_mask  out  NUM_REGS  one-hot scoreboard of pending destination.
- proto_err  out  1  sticky protocol-error flag.
REQ-005 The block shall use one clock; reset shall be asynchronous and active-high.

Function
REQ-006 Writing classes: R-type (00000) except mul (aluop 00110) and div (00111); addi (00101); lw (01000); jal (00011, dest 31); setx (10101, dest 30). All other opcodes shall not write.
REQ-007 Overflow shall redirect the write to r30 with data: add 1, addi 2, sub 3, mul 4, div 5.
REQ-008 Writes targeting r0 shall be suppressed, with ctrl_writeEnable staying 0.
REQ-009 Outputs shall be registered: a write accepted or resolved in cycle N shall appear on ctrl_* in cycle N+1 for exactly one cycle.
REQ-010 in_ready = ~md_resp_valid & ~(in_valid & writing & dest == pending rd & md_pending). Upstream shall hold the instruction while in_ready=0.
REQ-011 mul/div at W shall be accepted (in_ready rules apply) and shall produce no write.
REQ-012 FSM states:
- IDLE: md_issue -> PEND, latch rd and isdiv.
- PEND: md_resp_valid -> write result (or r30 code if md_resp_ovf), then IDLE.
- PEND with md_resp_valid and md_issue in the same cycle: write the old result, latch the new issue, stay PEND.
REQ-013 md_issue in PEND without md_resp_valid shall be ignored and shall set proto_err. md_resp_valid in IDLE shall be ignored and shall set proto_err.
REQ-014 md_pending shall equal (state==PEND). busy_mask shall be one-hot of the latched rd in PEND, and zero if that rd is 0 or the state is IDLE.
REQ-015 When md_resp_valid and in_valid coincide, the md result shall win and the W instruction shall stall exactly one cycle.

Reset
REQ-016 Reset shall force IDLE and clear ctrl_writeEnable, ctrl_writeReg, ctrl_writeData, md_pending, busy_mask and proto_err to 0. in_ready shall follow REQ-010 with state cleared.
REQ-017 Reset asserted mid-PEND shall discard the outstanding mult/div; a later md_resp_valid shall raise proto_err.

Structure
REQ-018 A shared package wb_pkg shall hold the opcode constants, ALU-op constants (add, sub, mul, div) and the rstatus codes 1-5.
REQ-019 One combinational sub-module, wb_decode, shall map opcode, aluop and rd to writes, dest and is_md.

Verification
REQ-020 addi r5 (in_data=7), no ovf -> next cycle we=1, reg=5, data=7; one cycle only.
REQ-021 add with in_ovf=1, rd=4 -> we=1, reg=30, data=1; jal -> reg=31; add to rd=0 -> we=0.
REQ-022 md_issue rd=9, mult; then W addi rd=9 -> in_ready=0, busy_mask bit 9 set until md_resp_valid data=0x20 -> reg 9=0x20, then addi accepted and written.
REQ-023 md_resp_valid and in_valid (lw rd=3) in same cycle -> md result written first, lw written the following cycle.
REQ-024 Div resp with md_resp_ovf=1 -> r30=5. Back-to-back resp+issue -> stays PEND with the new rd.
REQ-025 Reset mid-PEND -> md_pending=0, busy_mask=0; a later md_resp_valid -> no write, proto_err=1.
